// File: rtl/booth_divider_if.sv
// Request/response bundle for the signed sequential divider.
// The requester uses the master modport and the divider uses the slave modport.
interface booth_divider_if #(
    parameter int N = 8
);
    logic             valid;
    logic             ready;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             done;
    logic             div_zero;
    logic             overflow;

    modport master (
        output valid, dividend, divisor,
        input  ready, quotient, remainder, done, div_zero, overflow
    );

    modport slave (
        input  valid, dividend, divisor,
        output ready, quotient, remainder, done, div_zero, overflow
    );
endinterface

// File: rtl/booth_divider.sv
// Signed 2N/N divider built on a restoring shift/subtract loop over operand magnitudes.
// The latency is fixed at N+2 cycles from acceptance to done on every path, including the error paths.
module booth_divider #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    booth_divider_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [N-1:0]  HALF     = {1'b1, {(N-1){1'b0}}};

    logic [1:0]     state_q,     state_d;
    logic [2*N-1:0] dvd_q,       dvd_d;
    logic [N-1:0]   dvs_q,       dvs_d;
    logic           sq_q,        sq_d;
    logic           sr_q,        sr_d;
    logic [N-1:0]   dmag_q,      dmag_d;
    logic [N:0]     rem_acc_q,   rem_acc_d;
    logic [N-1:0]   quo_acc_q,   quo_acc_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic           pre_ovf_q,   pre_ovf_d;
    logic           zero_q,      zero_d;
    logic [N-1:0]   quotient_q,  quotient_d;
    logic [N-1:0]   remainder_q, remainder_d;
    logic           done_q,      done_d;
    logic           div_zero_q,  div_zero_d;
    logic           overflow_q,  overflow_d;

    logic [2*N-1:0] nmag;
    logic [N-1:0]   dmag_w;
    logic [N:0]     trial;
    logic [N:0]     trial_diff;
    logic           trial_ge;
    logic [N-1:0]   q_signed;
    logic [N-1:0]   r_signed;
    logic           ovf;

    // The most negative dividend negates to itself, which is exactly its unsigned magnitude.
    assign nmag   = dvd_q[2*N-1] ? -dvd_q : dvd_q;
    assign dmag_w = dvs_q[N-1]   ? -dvs_q : dvs_q;

    assign trial      = {rem_acc_q[N-1:0], quo_acc_q[N-1]};
    assign trial_ge   = trial >= {1'b0, dmag_q};
    assign trial_diff = trial - {1'b0, dmag_q};

    assign q_signed = sq_q ? -quo_acc_q : quo_acc_q;
    assign r_signed = sr_q ? -rem_acc_q[N-1:0] : rem_acc_q[N-1:0];

    // A negative quotient may reach magnitude 2^(N-1); a positive quotient may not.
    assign ovf = pre_ovf_q | (!sq_q & quo_acc_q[N-1]) | (sq_q & (quo_acc_q > HALF));

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        sq_d        = sq_q;
        sr_d        = sr_q;
        dmag_d      = dmag_q;
        rem_acc_d   = rem_acc_q;
        quo_acc_d   = quo_acc_q;
        cnt_d       = cnt_q;
        pre_ovf_d   = pre_ovf_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    dvd_d   = bus.dividend;
                    dvs_d   = bus.divisor;
                    sq_d    = bus.dividend[2*N-1] ^ bus.divisor[N-1];
                    sr_d    = bus.dividend[2*N-1];
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                dmag_d    = dmag_w;
                rem_acc_d = {1'b0, nmag[2*N-1:N]};
                quo_acc_d = nmag[N-1:0];
                cnt_d     = CNT_INIT;
                pre_ovf_d = nmag[2*N-1:N] >= dmag_w;
                zero_d    = dmag_w == '0;
                state_d   = S_ITER;
            end
            S_ITER: begin
                // The loop runs its full length even for error cases, which keeps the latency constant.
                rem_acc_d = trial_ge ? trial_diff : trial;
                quo_acc_d = {quo_acc_q[N-2:0], trial_ge};
                cnt_d     = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (zero_q) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    div_zero_d  = 1'b1;
                    overflow_d  = 1'b0;
                end else if (ovf) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    div_zero_d  = 1'b0;
                    overflow_d  = 1'b1;
                end else begin
                    quotient_d  = q_signed;
                    remainder_d = r_signed;
                    div_zero_d  = 1'b0;
                    overflow_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dvs_q       <= '0;
            sq_q        <= 1'b0;
            sr_q        <= 1'b0;
            dmag_q      <= '0;
            rem_acc_q   <= '0;
            quo_acc_q   <= '0;
            cnt_q       <= '0;
            pre_ovf_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            sq_q        <= sq_d;
            sr_q        <= sr_d;
            dmag_q      <= dmag_d;
            rem_acc_q   <= rem_acc_d;
            quo_acc_q   <= quo_acc_d;
            cnt_q       <= cnt_d;
            pre_ovf_q   <= pre_ovf_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.ready     = state_q == S_IDLE;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential signed divider: 2N-bit two's-complement dividend by N-bit two's-complement divisor, giving an N-bit quotient and N-bit remainder. It is the inverse companion of the team's Booth multiplier and undoes a 2N-bit product back into its N-bit factors. Core is a restoring shift/subtract datapath on operand magnitudes with a fixed-latency FSM. It uses the same valid/done handshake as the multiplier, so both blocks can share a controller.

## Interface
- N, default 8: divisor, quotient and remainder width. The dividend is 2N bits. N ≥ 2.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- valid  in  1  request strobe. Sampled only when ready=1.
- ready  out  1  high exactly when the FSM is in IDLE.
- dividend  in  2N  signed dividend. Captured on the accepting edge.
- divisor  in  N  signed divisor. Captured on the accepting edge.
- quotient  out  N  signed quotient, registered.
- remainder  out  N  signed remainder, registered.
- done  out  1  one-cycle pulse: results valid.
- div_zero  out  1  divisor was 0. Registered, updated together with done.
- overflow  out  1  true quotient is outside [-2^(N-1), 2^(N-1)-1]. Registered, updated together with done.

## Operation
- Semantics: truncating division toward zero.
  - dividend = quotient*divisor + remainder.
  - |remainder| < |divisor|.
  - remainder has the sign of the dividend, or is 0.
- States: IDLE, PREP, ITER, FIX.
- IDLE → PREP when valid=1.
  - Latch dividend and divisor.
  - Latch sq = dividend[2N-1]^divisor[N-1] (quotient sign).
  - Latch sr = dividend[2N-1] (remainder sign).
- PREP → ITER, one cycle.
  - Form unsigned magnitudes: dmag (N bits) and nmag (2N bits). nmag = 2^(2N-1) for the most negative dividend.
  - Load R (N+1 bits) = {0, nmag[2N-1:N]}.
  - Load Q (N bits) = nmag[N-1:0].
  - Load iteration counter = N.
  - Flag pre_ovf = (nmag[2N-1:N] ≥ dmag).
  - Flag zero = (dmag == 0).
- ITER, N cycles. Each cycle:
  - T = {R[N-1:0], Q[N-1]}.
  - If T ≥ dmag: R ← T-dmag and shift 1 into Q LSB. Otherwise R ← T and shift 0 in.
  - Decrement the counter. Leave ITER when it reaches 0.
  - Iterations always run, even when zero or pre_ovf is set.
- FIX → IDLE, one cycle. This edge registers outputs and sets done=1.
  - qs = sq ? -Q : Q.
  - rs = sr ? -R[N-1:0] : R[N-1:0].
  - ovf = pre_ovf | (!sq & Q[N-1]) | (sq & Q > 2^(N-1)).
  - If zero: quotient=0, remainder=0, div_zero=1, overflow=0.
  - Else if ovf: quotient=0, remainder=0, overflow=1, div_zero=0.
  - Else: quotient=qs, remainder=rs, both flags 0.
- Outputs hold their values until the next FIX edge. done drops after one cycle.
- valid while ready=0 is ignored. It is not queued.

## Timing
- Reset values: state IDLE, ready=1, done=0, quotient=0, remainder=0, div_zero=0, overflow=0. Internal registers are cleared.
- rst is asserted in any state: the next edge forces the full reset state and abandons any in-flight operation. No done pulse is issued for it.
- Acceptance edge k (valid=1, ready=1).
  - ready=0 from edge k through edge k+N+2.
  - FIX completes at edge k+N+2. done=1 in the cycle after it, alongside ready=1.
  - Fixed latency of N+2 cycles from acceptance to done, on all paths including errors.
- Back-to-back: valid=1 in the done cycle is accepted at that edge. Throughput is one result per N+3 cycles.
- Operand inputs need to be stable only at the acceptance edge.

## Test plan
- Reset/idle (N=8): apply rst for 2 cycles, then hold valid=0 → ready=1, done=0, all outputs 0, no done pulse for 20 cycles.
- Sign matrix (N=8), done exactly 10 cycles after each accept, flags 0:
  - 100/7 → q=14, r=2.
  - -100/7 → q=0xF2 (-14), r=0xFE (-2).
  - 100/-7 → q=0xF2, r=2.
  - -100/-7 → q=14, r=0xFE.
- Boundaries (N=8):
  - 0xFF80/1 → q=0x80, no overflow.
  - 128/-1 → q=0x80, no overflow.
  - 0xFF80/-1 → overflow=1, q=0.
  - 0x7FFF/1 → overflow=1 (via pre_ovf).
  - 0x8000/0x80 → q=0x7F... is wrong: the true quotient is +256, so overflow=1.
- Divide by zero: 1234/0 → div_zero=1, overflow=0, q=r=0, done still at N+2.
- Handshake:
  - Pulse valid mid-operation → ignored; the original result is unchanged.
  - Hold valid=1 continuously → accepts on each done cycle, period 11 cycles.
- Reset mid-ITER: assert rst 4 cycles after accept → next cycle ready=1 with outputs 0 and no done pulse. A following 50/5 → q=10, r=0.
- Reference check: 2000 random operand pairs, compared against a behavioural truncating-division model including the flags.
